// File: rtl/seq_min_max_pkg.sv
// rtl/seq_min_max_pkg.sv - shared FSM state type and default widths for seq_min_max
package seq_min_max_pkg;

    localparam int DEF_N     = 8;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_min_max_minmax_cmp.sv
// rtl/seq_min_max_minmax_cmp.sv - unsigned strict compares of a sample against running min/max
module minmax_cmp #(
    parameter int N = 8
) (
    input  logic [N-1:0] sample,
    input  logic [N-1:0] min,
    input  logic [N-1:0] max,
    output logic         lt_min,
    output logic         gt_max
);

    assign lt_min = sample < min;
    assign gt_max = sample > max;

endmodule

// File: rtl/seq_min_max.sv
// rtl/seq_min_max.sv - per-frame min/max/count tracker with held result handshake
// Optional SEQ_MIN_MAX_INDEX_EN adds first-occurrence index outputs m_min_idx/m_max_idx.
module seq_min_max
    import seq_min_max_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [N-1:0]     s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [N-1:0]     m_min,
    output logic [N-1:0]     m_max,
    output logic [CNT_W-1:0] m_count
`ifdef SEQ_MIN_MAX_INDEX_EN
    ,
    output logic [CNT_W-1:0] m_min_idx,
    output logic [CNT_W-1:0] m_max_idx
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [N-1:0]     acc_min_q, acc_min_d;
    logic [N-1:0]     acc_max_q, acc_max_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [N-1:0]     res_min_q, res_min_d;
    logic [N-1:0]     res_max_q, res_max_d;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
`ifdef SEQ_MIN_MAX_INDEX_EN
    logic [CNT_W-1:0] acc_min_idx_q, acc_min_idx_d;
    logic [CNT_W-1:0] acc_max_idx_q, acc_max_idx_d;
    logic [CNT_W-1:0] res_min_idx_q, res_min_idx_d;
    logic [CNT_W-1:0] res_max_idx_q, res_max_idx_d;
`endif

    logic accept;
    logic lt_min, gt_max;

    assign s_ready = (state_q != HOLD);
    assign m_valid = (state_q == HOLD);
    assign accept  = s_valid && s_ready;

    minmax_cmp #(.N(N)) u_cmp (
        .sample (s_data),
        .min    (acc_min_q),
        .max    (acc_max_q),
        .lt_min (lt_min),
        .gt_max (gt_max)
    );

    always_comb begin
        state_d   = state_q;
        acc_min_d = acc_min_q;
        acc_max_d = acc_max_q;
        acc_cnt_d = acc_cnt_q;
        res_min_d = res_min_q;
        res_max_d = res_max_q;
        res_cnt_d = res_cnt_q;
`ifdef SEQ_MIN_MAX_INDEX_EN
        acc_min_idx_d = acc_min_idx_q;
        acc_max_idx_d = acc_max_idx_q;
        res_min_idx_d = res_min_idx_q;
        res_max_idx_d = res_max_idx_q;
`endif
        if (accept) begin
            if (state_q == IDLE) begin
                acc_min_d = s_data;
                acc_max_d = s_data;
                acc_cnt_d = CNT_W'(1);
`ifdef SEQ_MIN_MAX_INDEX_EN
                acc_min_idx_d = '0;
                acc_max_idx_d = '0;
`endif
            end else begin
                // Pre-increment count is this sample's zero-based position and saturates with it.
                if (lt_min) begin
                    acc_min_d = s_data;
`ifdef SEQ_MIN_MAX_INDEX_EN
                    acc_min_idx_d = acc_cnt_q;
`endif
                end
                if (gt_max) begin
                    acc_max_d = s_data;
`ifdef SEQ_MIN_MAX_INDEX_EN
                    acc_max_idx_d = acc_cnt_q;
`endif
                end
                if (acc_cnt_q != CNT_MAX) begin
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                end
            end
            if (s_last) begin
                state_d   = HOLD;
                res_min_d = acc_min_d;
                res_max_d = acc_max_d;
                res_cnt_d = acc_cnt_d;
`ifdef SEQ_MIN_MAX_INDEX_EN
                res_min_idx_d = acc_min_idx_d;
                res_max_idx_d = acc_max_idx_d;
`endif
            end else begin
                state_d = ACCUM;
            end
        end else if (state_q == HOLD && m_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_min_q <= '0;
            acc_max_q <= '0;
            acc_cnt_q <= '0;
            res_min_q <= '0;
            res_max_q <= '0;
            res_cnt_q <= '0;
`ifdef SEQ_MIN_MAX_INDEX_EN
            acc_min_idx_q <= '0;
            acc_max_idx_q <= '0;
            res_min_idx_q <= '0;
            res_max_idx_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            acc_min_q <= acc_min_d;
            acc_max_q <= acc_max_d;
            acc_cnt_q <= acc_cnt_d;
            res_min_q <= res_min_d;
            res_max_q <= res_max_d;
            res_cnt_q <= res_cnt_d;
`ifdef SEQ_MIN_MAX_INDEX_EN
            acc_min_idx_q <= acc_min_idx_d;
            acc_max_idx_q <= acc_max_idx_d;
            res_min_idx_q <= res_min_idx_d;
            res_max_idx_q <= res_max_idx_d;
`endif
        end
    end

    assign m_min   = res_min_q;
    assign m_max   = res_max_q;
    assign m_count = res_cnt_q;
`ifdef SEQ_MIN_MAX_INDEX_EN
    assign m_min_idx = res_min_idx_q;
    assign m_max_idx = res_max_idx_q;
`endif

endmodule

// File: tb/tb_seq_min_max.sv
// tb/tb_seq_min_max.sv - self-checking bench: CNT_W=8 and CNT_W=2 instances against a frame model
module tb_seq_min_max;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_last = 1'b0;
    logic       m_ready = 1'b0;

    logic       a_s_ready, a_m_valid, b_s_ready, b_m_valid;
    logic [7:0] a_m_min, a_m_max, a_m_count, b_m_min, b_m_max;
    logic [1:0] b_m_count;
`ifdef SEQ_MIN_MAX_INDEX_EN
    logic [7:0] a_min_idx, a_max_idx;
    logic [1:0] b_min_idx, b_max_idx;
`endif

    always #5 clk = ~clk;

    seq_min_max #(.N(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(a_s_ready),
        .s_data(s_data), .s_last(s_last), .m_valid(a_m_valid), .m_ready(m_ready),
        .m_min(a_m_min), .m_max(a_m_max), .m_count(a_m_count)
`ifdef SEQ_MIN_MAX_INDEX_EN
        , .m_min_idx(a_min_idx), .m_max_idx(a_max_idx)
`endif
    );

    seq_min_max #(.N(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(b_s_ready),
        .s_data(s_data), .s_last(s_last), .m_valid(b_m_valid), .m_ready(m_ready),
        .m_min(b_m_min), .m_max(b_m_max), .m_count(b_m_count)
`ifdef SEQ_MIN_MAX_INDEX_EN
        , .m_min_idx(b_min_idx), .m_max_idx(b_max_idx)
`endif
    );

    int tests = 0;
    int fails = 0;

    int unsigned frame_q[$];
    logic [7:0] e_min, e_max, e_cnt_a, e_mni_a, e_mxi_a;
    logic [1:0] e_cnt_b, e_mni_b, e_mxi_b;
    logic [7:0] h_min, h_max, h_cnt_a;
    logic [1:0] h_cnt_b;

    function automatic int unsigned sat(input int unsigned v, input int unsigned lim);
        return (v > lim) ? lim : v;
    endfunction

    // Reference: min/max with first occurrence winning, counts and positions clipped to width.
    task automatic model();
        int unsigned mn, mx, mni, mxi;
        mn = frame_q[0]; mx = frame_q[0]; mni = 0; mxi = 0;
        for (int i = 1; i < frame_q.size(); i++) begin
            if (frame_q[i] < mn) begin mn = frame_q[i]; mni = i; end
            if (frame_q[i] > mx) begin mx = frame_q[i]; mxi = i; end
        end
        e_min   = 8'(mn);
        e_max   = 8'(mx);
        e_cnt_a = 8'(sat(frame_q.size(), 255));
        e_cnt_b = 2'(sat(frame_q.size(), 3));
        e_mni_a = 8'(sat(mni, 255));
        e_mxi_a = 8'(sat(mxi, 255));
        e_mni_b = 2'(sat(mni, 3));
        e_mxi_b = 2'(sat(mxi, 3));
    endtask

    task automatic send(input logic [7:0] d, input bit last, input int gap);
        repeat (gap) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            s_last  = 1'($urandom);
        end
        @(negedge clk);
        tests++;
        if ({a_s_ready, a_m_valid, b_s_ready, b_m_valid, a_m_min, a_m_max, a_m_count, b_m_count}
            !== {4'b1010, h_min, h_max, h_cnt_a, h_cnt_b}) begin
            fails++;
            $display("FAIL held_outputs: got rdy/vld=%b%b min=%0h max=%0h cnt=%0d/%0d want rdy/vld=10 min=%0h max=%0h cnt=%0d/%0d",
                     a_s_ready, a_m_valid, a_m_min, a_m_max, a_m_count, b_m_count, h_min, h_max, h_cnt_a, h_cnt_b);
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(posedge clk);
        frame_q.push_back(int'(d));
        if (last) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
            tests++;
            if ({a_m_valid, b_m_valid} !== 2'b11) begin
                fails++;
                $display("FAIL valid_latency: got m_valid=%b%b want 11", a_m_valid, b_m_valid);
            end
        end
    endtask

    // Checks the held result across bp stall cycles (with samples offered), then completes the handshake.
    task automatic finish_frame(input int bp, input string name);
        model();
        for (int c = 0; c <= bp; c++) begin
            tests++;
            if ({a_s_ready, a_m_valid, a_m_min, a_m_max, a_m_count, b_m_min, b_m_max, b_m_count}
                !== {2'b01, e_min, e_max, e_cnt_a, e_min, e_max, e_cnt_b}) begin
                fails++;
                $display("FAIL %s result c%0d: got rdy/vld=%b%b min=%0h max=%0h cnt=%0d cntB=%0d want min=%0h max=%0h cnt=%0d cntB=%0d",
                         name, c, a_s_ready, a_m_valid, a_m_min, a_m_max, a_m_count, b_m_count,
                         e_min, e_max, e_cnt_a, e_cnt_b);
            end
`ifdef SEQ_MIN_MAX_INDEX_EN
            tests++;
            if ({a_min_idx, a_max_idx, b_min_idx, b_max_idx} !== {e_mni_a, e_mxi_a, e_mni_b, e_mxi_b}) begin
                fails++;
                $display("FAIL %s index: got %0d %0d %0d %0d want %0d %0d %0d %0d", name,
                         a_min_idx, a_max_idx, b_min_idx, b_max_idx, e_mni_a, e_mxi_a, e_mni_b, e_mxi_b);
            end
`endif
            s_valid = (bp > 0);
            s_data  = 8'($urandom);
            s_last  = 1'($urandom);
            if (c == bp) m_ready = 1'b1;
            @(negedge clk);
        end
        tests++;
        if ({a_m_valid, a_s_ready, b_m_valid, b_s_ready} !== 4'b0101) begin
            fails++;
            $display("FAIL %s handshake: got vld/rdy=%b%b want 01", name, a_m_valid, a_s_ready);
        end
        m_ready = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        h_min = e_min; h_max = e_max; h_cnt_a = e_cnt_a; h_cnt_b = e_cnt_b;
        frame_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({a_m_valid, b_m_valid, a_m_min, a_m_max, a_m_count, b_m_min, b_m_max, b_m_count} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got vld=%b min=%0h max=%0h cnt=%0d want all 0",
                     a_m_valid, a_m_min, a_m_max, a_m_count);
        end
`ifdef SEQ_MIN_MAX_INDEX_EN
        tests++;
        if ({a_min_idx, a_max_idx, b_min_idx, b_max_idx} !== '0) begin
            fails++;
            $display("FAIL reset_index: got %0d %0d want 0 0", a_min_idx, a_max_idx);
        end
`endif
        s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({a_s_ready, b_s_ready, a_m_valid} !== 3'b110) begin
            fails++;
            $display("FAIL reset_release: got s_ready=%b%b m_valid=%b want 110", a_s_ready, b_s_ready, a_m_valid);
        end
        frame_q.delete();
        h_min = '0; h_max = '0; h_cnt_a = '0; h_cnt_b = '0;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_basic_frame();
        send(8'd5, 1'b0, 0); send(8'd3, 1'b0, 0); send(8'd9, 1'b0, 0); send(8'd3, 1'b1, 0);
        finish_frame(0, "frame_5393");
    endtask

    task automatic test_single_sample();
        send(8'hFF, 1'b1, 1);
        finish_frame(0, "single_ff");
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) send(8'($urandom), i == 3, 0);
        finish_frame(5, "backpressure");
        send(8'd10, 1'b0, 0); send(8'd20, 1'b1, 0);
        finish_frame(0, "after_backpressure");
    endtask

    task automatic test_saturation();
        for (int i = 1; i <= 6; i++) send(8'(i), i == 6, 0);
        finish_frame(1, "sat_1to6");
        for (int i = 0; i < 260; i++) send(8'($urandom_range(1, 254)), i == 259, 0);
        finish_frame(0, "sat_260");
    endtask

    task automatic test_reset_mid_frame();
        send(8'd50, 1'b0, 0); send(8'd60, 1'b0, 0);
        do_reset();
        send(8'd7, 1'b0, 0); send(8'd2, 1'b1, 0);
        finish_frame(0, "post_reset_72");
    endtask

    task automatic test_gaps();
        send(8'd4, 1'b0, 0); send(8'd1, 1'b1, 2);
        finish_frame(0, "gaps_41");
    endtask

    task automatic test_random();
        for (int f = 0; f < 20; f++) begin
            int len;
            bit narrow;
            len = $urandom_range(1, 12);
            narrow = 1'($urandom);
            for (int i = 0; i < len; i++) begin
                send(narrow ? 8'($urandom_range(0, 3)) : 8'($urandom), i == len - 1, $urandom_range(0, 2));
            end
            finish_frame($urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        h_min = '0; h_max = '0; h_cnt_a = '0; h_cnt_b = '0;
        test_reset();
        test_basic_frame();
        test_single_sample();
        test_backpressure();
        test_saturation();
        test_reset_mid_frame();
        test_gaps();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
